qea_state_reader: RTL and testbench



---
 rtl/qea_state_reader_if.sv | 22 ++
 rtl/qea_state_reader.sv | 163 ++++++++++++++++
 tb/tb_qea_state_reader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/qea_state_reader_if.sv
// Amplitude stream bundle between the QEA state reader and its sink:
// valid/ready handshake carrying one complex amplitude, its basis index and a last flag.
interface qea_state_reader_if #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 18
) ();
  logic              o_amp_valid;
  logic              i_amp_ready;
  logic [DATA_W-1:0] o_amp_data;
  logic [IDX_W-1:0]  o_amp_idx;
  logic              o_amp_last;

  modport master (
    output o_amp_valid, o_amp_data, o_amp_idx, o_amp_last,
    input  i_amp_ready
  );

  modport slave (
    input  o_amp_valid, o_amp_data, o_amp_idx, o_amp_last,
    output i_amp_ready
  );
endinterface

// File: rtl/qea_state_reader.sv
// Sweeps the QEA state RAM after a run and streams every complex amplitude,
// MSB slot of each RAM word first, with its basis-state index and a last flag.
module qea_state_reader #(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int STATE_DATA_WIDTH = DATA_WIDTH * 2,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int RAM_READ_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  output logic                               o_state_ena,
  output logic                               o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dout,
  qea_state_reader_if.master                 amp,
  output logic                               o_busy,
  output logic                               o_done
);

  localparam int WORD_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int IDX_W  = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int WAIT_W = (RAM_READ_LATENCY > 1) ? $clog2(RAM_READ_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_e;

  state_e                        state_q;
  logic [STATE_ADDR_WIDTH-1:0]   word_q;
  logic [STATE_ADDR_WIDTH-1:0]   last_word_q;
  logic [PE_NUM_WIDTH-1:0]       slot_q;
  logic [WAIT_W-1:0]             wait_q;
  logic [WORD_W-1:0]             buf_q;
  logic                          ena_q;
  logic [STATE_ADDR_WIDTH-1:0]   addr_q;
  logic                          valid_q;
  logic [STATE_DATA_WIDTH-1:0]   data_q;
  logic [IDX_W-1:0]              idx_q;
  logic                          last_q;
  logic                          busy_q;
  logic                          done_q;

  logic [MAX_QBIT_WIDTH-1:0]     nq_d;
  logic [STATE_ADDR_WIDTH:0]     words_d;
  logic [STATE_ADDR_WIDTH-1:0]   last_word_d;
  logic [PE_NUM_WIDTH-1:0]       slot_d;
  logic [STATE_DATA_WIDTH-1:0]   next_data_d;
  logic [STATE_DATA_WIDTH-1:0]   first_data_d;
  logic                          hs;
  logic                          final_slot;
  logic                          final_word;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    nq_d = i_qbit_num;
    if (i_qbit_num < MAX_QBIT_WIDTH'(2)) begin
      nq_d = MAX_QBIT_WIDTH'(2);
    end else if (i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2)) begin
      nq_d = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2);
    end
    words_d     = (STATE_ADDR_WIDTH+1)'(1) << (nq_d - MAX_QBIT_WIDTH'(2));
    last_word_d = STATE_ADDR_WIDTH'(words_d - (STATE_ADDR_WIDTH+1)'(1));
  end

  assign slot_d       = slot_q + PE_NUM_WIDTH'(1);
  assign next_data_d  = buf_q[(PE_NUM - 1 - int'(slot_d)) * STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
  assign first_data_d = i_state_dout[(PE_NUM - 1) * STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
  assign hs           = valid_q && amp.i_amp_ready;
  assign final_slot   = (slot_q == PE_NUM_WIDTH'(PE_NUM - 1));
  assign final_word   = (word_q == last_word_q);

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      last_word_q <= '0;
      slot_q      <= '0;
      wait_q      <= '0;
      // NOTE: the word buffer is reset as well, so no stale amplitude survives an aborted stream.
      buf_q       <= '0;
      ena_q       <= 1'b0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ena_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            last_word_q <= last_word_d;
            word_q      <= '0;
            addr_q      <= '0;
            ena_q       <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= READ;
          end
        end
        READ: begin
          wait_q  <= WAIT_W'(RAM_READ_LATENCY - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == '0) begin
            buf_q   <= i_state_dout;
            slot_q  <= '0;
            valid_q <= 1'b1;
            data_q  <= first_data_d;
            idx_q   <= {word_q, PE_NUM_WIDTH'(0)};
            last_q  <= 1'b0;
            state_q <= EMIT;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        EMIT: begin
          if (hs) begin
            if (final_slot) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (final_word) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                word_q  <= word_q + STATE_ADDR_WIDTH'(1);
                addr_q  <= word_q + STATE_ADDR_WIDTH'(1);
                ena_q   <= 1'b1;
                state_q <= READ;
              end
            end else begin
              slot_q <= slot_d;
              data_q <= next_data_d;
              idx_q  <= idx_q + IDX_W'(1);
              last_q <= final_word && (slot_d == PE_NUM_WIDTH'(PE_NUM - 1));
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_state_ena     = ena_q;
  assign o_state_wea     = 1'b0;
  assign o_state_addra   = addr_q;
  assign amp.o_amp_valid = valid_q;
  assign amp.o_amp_data  = data_q;
  assign amp.o_amp_idx   = idx_q;
  assign amp.o_amp_last  = last_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

endmodule

// File: tb/tb_qea_state_reader.sv
// Directed bench for qea_state_reader: a behavioural one-cycle-latency state RAM,
// stream checks against a per-amplitude expected model and hand-derived cycle numbers.
module tb_qea_state_reader;

  localparam int SDW   = 64;
  localparam int IDX_W = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [5:0]   i_qbit_num = '0;
  logic         o_state_ena;
  logic         o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] ram_dout = '0;
  logic         o_busy;
  logic         o_done;

  qea_state_reader_if #(.DATA_W(SDW), .IDX_W(IDX_W)) amp_if ();

  qea_state_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_qbit_num    (i_qbit_num),
    .o_state_ena   (o_state_ena),
    .o_state_wea   (o_state_wea),
    .o_state_addra (o_state_addra),
    .i_state_dout  (ram_dout),
    .amp           (amp_if),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit ram_mode = 1'b0;

  // mode 0: only word 0 slot 0 holds 1.0; mode 1: word k holds {4k, 4k+1, 4k+2, 4k+3}, MSB first
  function automatic logic [255:0] ram_word(input bit mode, input logic [15:0] a);
    logic [63:0] k;
    k = 64'(a);
    if (mode) return {k * 4, k * 4 + 64'd1, k * 4 + 64'd2, k * 4 + 64'd3};
    return (a == 16'd0) ? {64'h4000_0000_0000_0000, 192'd0} : 256'd0;
  endfunction

  function automatic logic [63:0] exp_amp(input bit mode, input int i);
    if (mode) return 64'(i);
    return (i == 0) ? 64'h4000_0000_0000_0000 : 64'd0;
  endfunction

  always @(posedge clk) begin
    if (o_state_ena) ram_dout <= ram_word(ram_mode, o_state_addra);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"},   o_state_ena,        0);
    check({tag, "_wea"},   o_state_wea,        0);
    check({tag, "_addr"},  o_state_addra,      0);
    check({tag, "_valid"}, amp_if.o_amp_valid, 0);
    check({tag, "_data"},  amp_if.o_amp_data,  0);
    check({tag, "_idx"},   amp_if.o_amp_idx,   0);
    check({tag, "_last"},  amp_if.o_amp_last,  0);
    check({tag, "_busy"},  o_busy,             0);
    check({tag, "_done"},  o_done,             0);
  endtask

  // Starts a readout and follows it cycle by cycle. Cycle 0 is the i_start cycle.
  // With ready held high, word w issues its read in cycle 6w+1 and slot s handshakes in 6w+3+s.
  task automatic run_stream(input logic [5:0] qn, input int n_amp, input bit mode,
                            input bit rand_ready, input int busy_start_cyc, input int stop_cyc);
    int          hs = 0;
    int          enas = 0;
    int          n_words;
    bit          finished = 1'b0;
    bit          stopped = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] pd = '0;
    logic [17:0] pidx = '0;
    logic        plast = 1'b0;
    n_words  = n_amp / 4;
    ram_mode = mode;
    @(negedge clk);
    i_qbit_num = qn;
    i_start    = 1'b1;
    amp_if.i_amp_ready = 1'b1;
    cyc = 0;
    while (!finished) begin
      @(negedge clk);
      cyc++;
      i_start = (cyc == busy_start_cyc);
      if (cyc == busy_start_cyc) i_qbit_num = 6'd3;
      amp_if.i_amp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stop_cyc != 0 && cyc == stop_cyc) begin
        stopped  = 1'b1;
        finished = 1'b1;
      end else begin
        if (prev_stall) begin
          check("stall_valid", amp_if.o_amp_valid, 1);
          check("stall_data",  amp_if.o_amp_data,  pd);
          check("stall_idx",   amp_if.o_amp_idx,   pidx);
          check("stall_last",  amp_if.o_amp_last,  plast);
        end
        if (o_state_ena) begin
          check("ena_addr", o_state_addra, enas);
          if (!rand_ready) check("ena_cycle", cyc, enas * 6 + 1);
          enas++;
        end
        if (amp_if.o_amp_valid && amp_if.i_amp_ready) begin
          check("amp_idx",  amp_if.o_amp_idx,  hs);
          check("amp_data", amp_if.o_amp_data, exp_amp(mode, hs));
          check("amp_last", amp_if.o_amp_last, (hs == n_amp - 1));
          if (!rand_ready) check("amp_cycle", cyc, (hs / 4) * 6 + 3 + (hs % 4));
          hs++;
        end
        prev_stall = amp_if.o_amp_valid && !amp_if.i_amp_ready;
        pd    = amp_if.o_amp_data;
        pidx  = amp_if.o_amp_idx;
        plast = amp_if.o_amp_last;
        if (o_done) begin
          check("done_amp_count", hs, n_amp);
          check("done_ena_count", enas, n_words);
          check("done_busy_low",  o_busy, 0);
          if (!rand_ready) check("done_cycle", cyc, n_words * 6 + 1);
          finished = 1'b1;
        end else begin
          check("busy_high", o_busy, 1);
        end
        if (cyc > 4000) begin
          check("timeout", 0, 1);
          finished = 1'b1;
        end
      end
    end
    i_start = 1'b0;
    if (!stopped) begin
      @(negedge clk);
      check("post_done_pulse", o_done, 0);
      check("post_busy",       o_busy, 0);
      check("post_valid",      amp_if.o_amp_valid, 0);
    end
  endtask

  initial begin
    amp_if.i_amp_ready = 1'b0;

    // Reset with random inputs, including i_start
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_start            = 1'b1;
      i_qbit_num         = 6'($urandom_range(0, 63));
      amp_if.i_amp_ready = 1'($urandom_range(0, 1));
      check_all_zero("reset");
    end
    i_start = 1'b0;
    rst_n   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_start_ignored_busy", o_busy, 0);
    check("reset_start_ignored_ena",  o_state_ena, 0);

    // 8-qubit readout: 64 words, last in cycle 384, done in 385
    run_stream(6'd8, 256, 1'b0, 1'b0, 0, 0);

    // Backpressure with random ready, 4 qubits
    run_stream(6'd4, 16, 1'b1, 1'b1, 0, 0);

    // Minimum size: 2 and 1 qubit both read a single word
    run_stream(6'd2, 4, 1'b1, 1'b0, 0, 0);
    run_stream(6'd1, 4, 1'b1, 1'b0, 0, 0);

    // Start while busy is ignored
    run_stream(6'd8, 256, 1'b1, 1'b0, 50, 0);

    // Reset during EMIT of word 5 (cycles 33..36), then a clean restart
    run_stream(6'd5, 32, 1'b1, 1'b0, 0, 34);
    check("abort_in_emit_valid", amp_if.o_amp_valid, 1);
    check("abort_in_emit_idx",   amp_if.o_amp_idx,   21);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    check_all_zero("abort_hold");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_resume", o_busy, 0);
    run_stream(6'd4, 16, 1'b1, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
